// File: rtl/phase_meas_ctrl.sv
// Multi-channel X-to-Y phase sequencer: scans enabled channel pairs, averages
// 2^AVG_LOG2 rise-to-rise delays per channel and returns one result per channel.
module phase_meas_ctrl #(
  parameter int N_CH     = 4,
  parameter int CW       = 32,
  parameter int AVG_LOG2 = 3,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_CH-1:0]         ch_mask,
  input  logic [N_CH-1:0]         sig_x,
  input  logic [N_CH-1:0]         sig_y,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(N_CH)-1:0] res_ch,
  output logic [CW-1:0]           res_phase,
  output logic                    res_timeout,
  output logic                    done
);

  localparam int SW = $clog2(N_CH);
  localparam int AW = CW + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_COUNT = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [NW-1:0] N_SAMP  = NW'(2**AVG_LOG2);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);

  logic [2:0]      state;
  logic [N_CH-1:0] mask_r;
  logic [SW-1:0]   sel;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   sample;
  logic [AW-1:0]   acc;
  logic [NW-1:0]   n_samp;
  logic [TW-1:0]   timer;
  logic            done_empty;

  // Two synchronizer stages followed by the previous-value register for edge detection.
  logic [N_CH-1:0] x_s1, x_s2, x_prev;
  logic [N_CH-1:0] y_s1, y_s2, y_prev;

  // NOTE: every clocked register uses non-blocking assignment so all stages
  // update from the same pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_s1   <= '0;
      x_s2   <= '0;
      x_prev <= '0;
      y_s1   <= '0;
      y_s2   <= '0;
      y_prev <= '0;
    end else begin
      x_s1   <= sig_x;
      x_s2   <= x_s1;
      x_prev <= x_s2;
      y_s1   <= sig_y;
      y_s2   <= y_s1;
      y_prev <= y_s2;
    end
  end

  logic [N_CH-1:0] rise_x, rise_y;
  logic            rx, ry;
  assign rise_x = x_s2 & ~x_prev;
  assign rise_y = y_s2 & ~y_prev;
  assign rx     = rise_x[sel];
  assign ry     = rise_y[sel];

  // Lowest set bit of the incoming mask, and next set bit above sel in the latched mask.
  logic [SW-1:0] first_idx, next_idx;
  logic          first_ok, next_ok;

  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    first_idx = '0;
    first_ok  = 1'b0;
    next_idx  = '0;
    next_ok   = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_idx = SW'(i);
        first_ok  = 1'b1;
      end
      if (mask_r[i] && (i > int'(sel))) begin
        next_idx = SW'(i);
        next_ok  = 1'b1;
      end
    end
  end

  logic [CW-1:0] cnt_inc;
  logic [AW-1:0] acc_sum;
  logic [NW-1:0] n_samp_inc;
  logic          last_ch;

  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign acc_sum    = acc + AW'(sample);
  assign n_samp_inc = n_samp + 1'b1;
  assign last_ch    = (state == S_NEXT) && !next_ok;

  assign res_valid = (state == S_OUT);
  assign res_ch    = sel;
  assign done      = done_empty | last_ch;
  assign busy      = (state != S_IDLE) && !last_ch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      mask_r      <= '0;
      sel         <= '0;
      cnt         <= '0;
      sample      <= '0;
      acc         <= '0;
      n_samp      <= '0;
      timer       <= '0;
      res_phase   <= '0;
      res_timeout <= 1'b0;
      done_empty  <= 1'b0;
    end else begin
      done_empty <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start coinciding with the empty-mask done pulse is dropped.
          if (start && !done_empty) begin
            mask_r <= ch_mask;
            sel    <= first_idx;
            acc    <= '0;
            n_samp <= '0;
            timer  <= '0;
            if (first_ok) state <= S_ARM;
            else          done_empty <= 1'b1;
          end
        end

        S_ARM, S_COUNT, S_ACC: begin
          timer <= timer + 1'b1;
          if (timer == T_LAST) begin
            res_phase   <= '0;
            res_timeout <= 1'b1;
            state       <= S_OUT;
          end else if (state == S_ACC) begin
            acc    <= acc_sum;
            n_samp <= n_samp_inc;
            if (n_samp_inc == N_SAMP) begin
              res_phase   <= CW'(acc_sum >> AVG_LOG2);
              res_timeout <= 1'b0;
              state       <= S_OUT;
            end else begin
              state <= S_ARM;
            end
          end else if (rx && ry) begin
            sample <= '0;
            state  <= S_ACC;
          end else if (rx) begin
            // Latest X edge wins: a fresh reference restarts the delay count.
            cnt   <= '0;
            state <= S_COUNT;
          end else if (state == S_COUNT) begin
            if (ry) begin
              sample <= cnt_inc == cnt ? CNT_MAX : cnt + 1'b1;
              state  <= S_ACC;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        S_OUT: begin
          if (res_ready) state <= S_NEXT;
        end

        S_NEXT: begin
          acc    <= '0;
          n_samp <= '0;
          timer  <= '0;
          if (next_ok) begin
            sel   <= next_idx;
            state <= S_ARM;
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_meas_ctrl.sv
// Scoreboard bench for phase_meas_ctrl: directed scans push expected results,
// independent monitors pop and compare whenever a result is presented.
module tb_phase_meas_ctrl;

  localparam int N_CH = 4;
  localparam int CW   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [N_CH-1:0] ch_mask = '0;
  logic [N_CH-1:0] sig_x = '0;
  logic [N_CH-1:0] sig_y = '0;
  logic            res_ready = 1'b1;
  logic            busy, res_valid, res_timeout, done;
  logic [1:0]      res_ch;
  logic [CW-1:0]   res_phase;

  logic            to_start = 1'b0;
  logic [N_CH-1:0] to_mask = '0;
  logic [N_CH-1:0] to_sig_x = '0;
  logic            to_ready = 1'b1;
  logic            to_busy, to_valid, to_timeout, to_done;
  logic [1:0]      to_ch;
  logic [CW-1:0]   to_phase;

  phase_meas_ctrl #(.N_CH(N_CH), .CW(CW), .AVG_LOG2(3), .TIMEOUT(1000000)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .sig_x(sig_x), .sig_y(sig_y),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_phase(res_phase), .res_timeout(res_timeout), .done(done)
  );

  phase_meas_ctrl #(.N_CH(N_CH), .CW(CW), .AVG_LOG2(3), .TIMEOUT(500)) dut_to (
    .clk(clk), .rst(rst), .start(to_start), .ch_mask(to_mask), .sig_x(to_sig_x), .sig_y(sig_y),
    .busy(to_busy), .res_valid(to_valid), .res_ready(to_ready), .res_ch(to_ch),
    .res_phase(to_phase), .res_timeout(to_timeout), .done(to_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] phase;
    logic        to;
  } exp_t;

  exp_t q[$];
  exp_t q_to[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int n_to_done = 0;
  int busy_gap = 0;
  int stall_len = 0;
  int to_valid_cyc = -1;

  // Waveform model: common period, per-channel Y lag alternating between lag_a and lag_b.
  int per = 100;
  int lag_a[N_CH];
  int lag_b[N_CH];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int ch, input int ph, input bit to);
    exp_t e;
    e.ch    = 2'(ch);
    e.phase = 32'(ph);
    e.to    = to;
    return e;
  endfunction

  function automatic logic y_at(input int c, input int t);
    int k = t / per;
    for (int j = k - 1; j <= k; j++) begin
      if (j >= 0) begin
        int s = j * per + (((j % 2) != 0) ? lag_b[c] : lag_a[c]);
        if (t >= s && t < s + per / 2) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) begin
        sig_x[c] = ((cyc % per) < per / 2);
        sig_y[c] = y_at(c, cyc);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) n_done++;
      if (to_done) n_to_done++;
    end
  end

  // Main monitor: captures a presented result, verifies it holds while stalled,
  // and compares it against the scoreboard when the transfer happens.
  initial begin
    bit         held = 0;
    bit         stable = 1;
    int         wait_cnt = 0;
    logic [1:0] cap_ch = '0;
    logic [31:0] cap_ph = '0;
    logic       cap_to = 1'b0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 0;
      end else if (res_valid) begin
        if (!held) begin
          held = 1; stable = 1; wait_cnt = 0;
          cap_ch = res_ch; cap_ph = res_phase; cap_to = res_timeout;
        end else if (res_ch !== cap_ch || res_phase !== cap_ph || res_timeout !== cap_to || !busy) begin
          stable = 0;
        end
        if (!res_ready) begin
          wait_cnt++;
          if (wait_cnt >= stall_len) res_ready = 1'b1;
        end
        if (res_ready) begin
          held = 0;
          if (q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            e = q.pop_front();
            check("res_ch", 64'(cap_ch), 64'(e.ch));
            check("res_phase", 64'(cap_ph), 64'(e.phase));
            check("res_timeout", 64'(cap_to), 64'(e.to));
            check("held_stable", 64'(stable), 1);
          end
        end
      end else begin
        res_ready = (stall_len == 0);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && to_valid) begin
        if (q_to.size() == 0) begin
          check("to_unexpected_result", 1, 0);
        end else begin
          e = q_to.pop_front();
          check("to_res_ch", 64'(to_ch), 64'(e.ch));
          check("to_res_phase", 64'(to_phase), 64'(e.phase));
          check("to_res_timeout", 64'(to_timeout), 64'(e.to));
          to_valid_cyc = cyc;
        end
      end
    end
  end

  task automatic set_wave(input int p, input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
    per = p;
    lag_a[0] = a0; lag_a[1] = a1; lag_a[2] = a2; lag_a[3] = a3;
    lag_b[0] = b0; lag_b[1] = b1; lag_b[2] = b2; lag_b[3] = b3;
    repeat (2 * p + 10) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [N_CH-1:0] m);
    @(negedge clk);
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_gap++;
    end
    check({name, "_done_seen"}, 64'(seen), 1);
    if (seen) check({name, "_busy_low_at_done"}, 64'(busy), 0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 64'(busy), 0);
    check({name, "_res_valid"}, 64'(res_valid), 0);
    check({name, "_res_ch"}, 64'(res_ch), 0);
    check({name, "_res_phase"}, 64'(res_phase), 0);
    check({name, "_res_timeout"}, 64'(res_timeout), 0);
    check({name, "_done"}, 64'(done), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, lat, arm_cyc;
    for (int c = 0; c < N_CH; c++) begin
      lag_a[c] = 0;
      lag_b[c] = 0;
    end

    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Identical X/Y on ch0: zero delay.
    set_wave(100, 0, 0, 0, 0, 0, 0, 0, 0);
    d0 = n_done;
    q.push_back(mk(0, 0, 0));
    pulse_start(4'b0001);
    busy_gap = 0;
    wait_done("no_delay", 2000);
    check("no_delay_busy_gap", 64'(busy_gap), 0);
    check("no_delay_queue_empty", 64'(q.size()), 0);

    // Fixed 17-cycle lag on ch2.
    set_wave(40, 0, 0, 17, 0, 0, 0, 17, 0);
    q.push_back(mk(2, 17, 0));
    pulse_start(4'b0100);
    wait_done("lag17", 1000);
    check("lag17_queue_empty", 64'(q.size()), 0);

    // Alternating 10/13 lag: average 11.5 truncates to 11.
    set_wave(40, 0, 0, 10, 0, 0, 0, 13, 0);
    q.push_back(mk(2, 11, 0));
    pulse_start(4'b0100);
    wait_done("lag_alt", 1000);
    check("lag_alt_queue_empty", 64'(q.size()), 0);
    check("done_count_so_far", 64'(n_done - d0), 3);

    // Three channels with backpressure and an ignored mid-scan start.
    set_wave(30, 5, 6, 2, 8, 5, 6, 2, 8);
    stall_len = 20;
    d0 = n_done;
    q.push_back(mk(0, 5, 0));
    q.push_back(mk(1, 6, 0));
    q.push_back(mk(3, 8, 0));
    pulse_start(4'b1011);
    busy_gap = 0;
    repeat (100) @(negedge clk);
    pulse_start(4'b0100);
    wait_done("multi", 3000);
    check("multi_busy_gap", 64'(busy_gap), 0);
    check("multi_queue_empty", 64'(q.size()), 0);
    repeat (5) @(negedge clk);
    check("multi_done_pulses", 64'(n_done - d0), 1);
    stall_len = 0;
    res_ready = 1'b1;

    // Empty mask: done one cycle later, no result.
    d0 = n_done;
    pulse_start(4'b0000);
    check("empty_done", 64'(done), 1);
    check("empty_busy", 64'(busy), 0);
    @(negedge clk);
    check("empty_done_single", 64'(done), 0);
    repeat (20) @(negedge clk);
    check("empty_done_pulses", 64'(n_done - d0), 1);

    // Timeout on the TIMEOUT=500 instance: ch1 has no X edges.
    q_to.push_back(mk(1, 0, 1));
    @(negedge clk);
    to_mask  = 4'b0010;
    to_start = 1'b1;
    @(negedge clk);
    to_start = 1'b0;
    arm_cyc  = cyc;
    for (int i = 0; i < 700 && q_to.size() != 0; i++) @(negedge clk);
    check("to_result_seen", 64'(q_to.size()), 0);
    lat = to_valid_cyc - arm_cyc;
    check("to_latency_in_498_502", 64'((lat >= 498 && lat <= 502) ? 1 : 0), 1);
    repeat (5) @(negedge clk);
    check("to_done_pulses", 64'(n_to_done), 1);

    // Reset in the middle of a COUNT on ch1, then a clean full scan.
    set_wave(40, 3, 17, 9, 21, 3, 17, 9, 21);
    pulse_start(4'b0010);
    repeat (45) @(negedge clk);
    while ((cyc % 40) != 12) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("after_reset");
    d0 = n_done;
    q.push_back(mk(0, 3, 0));
    q.push_back(mk(1, 17, 0));
    q.push_back(mk(2, 9, 0));
    q.push_back(mk(3, 21, 0));
    pulse_start(4'b1111);
    busy_gap = 0;
    wait_done("rescan", 4000);
    check("rescan_busy_gap", 64'(busy_gap), 0);
    check("rescan_queue_empty", 64'(q.size()), 0);
    repeat (5) @(negedge clk);
    check("rescan_done_pulses", 64'(n_done - d0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
